// File: rtl/capture_seq_ctrl_pkg.sv
// Shared types and register field positions for the capture1 snapshot sequencer.
package capture_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int CTRL_ARM     = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_MODE_LO = 2;
  localparam int CTRL_CH_LO   = 8;
  localparam int CTRL_LEN_LO  = 16;

  localparam logic [1:0] MODE_IMM    = 2'd0;
  localparam logic [1:0] MODE_THRESH = 2'd1;

  localparam int THR_LO = 16;
  localparam int THR_W  = 15;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ARMED  = 2;
  localparam int STAT_CLIP   = 3;
  localparam int STAT_CNT_LO = 16;

endpackage

// File: rtl/capture_seq_ctrl_if.sv
// Phase-stream input and capture-BRAM write port of the capture sequencer.
interface capture_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int CH_W   = 8,
  parameter int ADDR_W = 10
) ();

  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_valid, in_ch, in_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_ch, in_data,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/capture_seq_ctrl_trig_detect.sv
// Combinational channel match and below-baseline trigger compare.
module capture_trig_detect
  import capture_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH_W   = 8
) (
  input  logic [1:0]        mode,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [DATA_W-1:0] baseline,
  input  logic [THR_W-1:0]  threshold,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              sel,
  output logic              trig
);

  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W+1:0] diff_x;
  logic signed [DATA_W+1:0] neg_thr;

  // One extra bit for the subtract and one more for the compare keeps full-scale excursions from wrapping.
  always_comb begin
    diff    = $signed({in_data[DATA_W-1], in_data}) - $signed({baseline[DATA_W-1], baseline});
    diff_x  = {diff[DATA_W], diff};
    neg_thr = -$signed({{(DATA_W+2-THR_W){1'b0}}, threshold});
    sel     = in_valid && (in_ch == ch_sel);
    trig    = sel && ((mode != MODE_THRESH) || (diff_x <= neg_thr));
  end

endmodule

// File: rtl/capture_seq_ctrl.sv
// Capture1 sequencer: arm on a software edge, trigger, write len+1 samples of one channel.
module capture_seq_ctrl
  import capture_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH_W   = 8,
  parameter int ADDR_W = 10
) (
  input  logic         user_clk,
  input  logic         user_rst_n,
  input  logic [31:0]  ctrl_reg,
  input  logic [31:0]  base_kq,
  capture_seq_ctrl_if.slave io,
  output logic [31:0]  status_reg
);

  localparam logic [15:0] LEN_MAX = 16'((1 << ADDR_W) - 1);

  state_t            state_q, state_d;
  logic              arm_q;
  logic              arm_edge, abort;
  logic [CH_W-1:0]   ch_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] base_q;
  logic [THR_W-1:0]  thr_q;
  logic [ADDR_W-1:0] len_q;
  logic              clip_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [15:0]       len_req;
  logic              sel, trig, last, wr_go, latch_go;
  logic [31:0]       status_d;
  logic              unused_bits;

  assign unused_bits = ^{ctrl_reg[7:4], base_kq[31]};
  assign arm_edge    = ctrl_reg[CTRL_ARM] & ~arm_q;
  assign abort       = ctrl_reg[CTRL_ABORT];
  assign len_req     = ctrl_reg[CTRL_LEN_LO +: 16];
  assign last        = (wcnt_q == {1'b0, len_q});

  capture_trig_detect #(
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_trig (
    .mode      (mode_q),
    .ch_sel    (ch_q),
    .baseline  (base_q),
    .threshold (thr_q),
    .in_valid  (io.in_valid),
    .in_ch     (io.in_ch),
    .in_data   (io.in_data),
    .sel       (sel),
    .trig      (trig)
  );

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= ST_IDLE;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= ctrl_reg[CTRL_ARM];
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: if (arm_edge) state_d = ST_ARMED;
        ST_ARMED:         if (trig)     state_d = last ? ST_DONE : ST_CAPTURE;
        ST_CAPTURE:       if (sel && last) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    latch_go = ~abort & arm_edge & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    wr_go    = ~abort & (((state_q == ST_ARMED) & trig) | ((state_q == ST_CAPTURE) & sel));
    status_d = '0;
    status_d[STAT_BUSY]  = (state_q == ST_ARMED) | (state_q == ST_CAPTURE);
    status_d[STAT_DONE]  = (state_q == ST_DONE);
    status_d[STAT_ARMED] = (state_q == ST_ARMED);
    status_d[STAT_CLIP]  = clip_q;
    status_d[STAT_CNT_LO +: 16] = 16'(wcnt_q);
  end

  // Software register contents only matter at the arm edge; later edits are ignored until re-arm.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ch_q   <= '0;
      mode_q <= MODE_IMM;
      base_q <= '0;
      thr_q  <= '0;
      len_q  <= '0;
      clip_q <= 1'b0;
      wcnt_q <= '0;
    end else if (abort) begin
      clip_q <= 1'b0;
    end else if (latch_go) begin
      ch_q   <= ctrl_reg[CTRL_CH_LO +: CH_W];
      mode_q <= ctrl_reg[CTRL_MODE_LO +: 2];
      base_q <= base_kq[DATA_W-1:0];
      thr_q  <= base_kq[THR_LO +: THR_W];
      len_q  <= (len_req > LEN_MAX) ? LEN_MAX[ADDR_W-1:0] : len_req[ADDR_W-1:0];
      clip_q <= (len_req > LEN_MAX);
      wcnt_q <= '0;
    end else if (wr_go) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      io.wr_en   <= 1'b0;
      io.wr_addr <= '0;
      io.wr_data <= '0;
      status_reg <= '0;
    end else begin
      io.wr_en   <= wr_go;
      status_reg <= status_d;
      if (wr_go) begin
        io.wr_addr <= wcnt_q[ADDR_W-1:0];
        io.wr_data <= io.in_data;
      end
    end
  end

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Directed bench for capture_seq_ctrl with a transaction-level reference model.
module tb_capture_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] ctrl;
  logic [31:0] base;
  logic [31:0] status;

  capture_seq_ctrl_if #(.DATA_W(16), .CH_W(8), .ADDR_W(10)) io ();

  capture_seq_ctrl #(.DATA_W(16), .CH_W(8), .ADDR_W(10)) dut (
    .user_clk   (clk),
    .user_rst_n (rst_n),
    .ctrl_reg   (ctrl),
    .base_kq    (base),
    .io         (io.slave),
    .status_reg (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phases 0 idle, 1 waiting, 2 collecting, 3 finished.
  int          m_st, m_cnt, m_len, m_base, m_thr;
  bit          m_prev_arm, m_clip, m_thr_mode, m_edge;
  logic [7:0]  m_ch;
  bit          exp_we;
  logic [9:0]  exp_addr;
  logic [15:0] exp_data;
  logic [31:0] exp_status;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_cnt = 0; m_len = 0; m_base = 0; m_thr = 0;
        m_prev_arm = 0; m_clip = 0; m_thr_mode = 0; m_ch = 0;
        exp_we = 0; exp_addr = 0; exp_data = 0; exp_status = 0;
      end else begin
        exp_status = {16'(m_cnt), 12'd0, m_clip, m_st == 1, m_st == 3, m_st == 1 || m_st == 2};
        m_edge = ctrl[0] && !m_prev_arm;
        m_prev_arm = ctrl[0];
        exp_we = 0;
        if (ctrl[1]) begin
          m_st = 0;
          m_clip = 0;
        end else if (m_edge && (m_st == 0 || m_st == 3)) begin
          m_ch = ctrl[15:8];
          m_thr_mode = (ctrl[3:2] == 2'd1);
          m_base = int'($signed(base[15:0]));
          m_thr = int'(base[30:16]);
          m_clip = (ctrl[31:16] > 16'd1023);
          m_len = m_clip ? 1023 : int'(ctrl[31:16]);
          m_cnt = 0;
          m_st = 1;
        end else if (io.in_valid && io.in_ch == m_ch &&
                     (m_st == 2 || (m_st == 1 &&
                      (!m_thr_mode || int'($signed(io.in_data)) - m_base <= -m_thr)))) begin
          exp_we = 1;
          exp_addr = 10'(m_cnt);
          exp_data = io.in_data;
          m_cnt++;
          m_st = (m_cnt > m_len) ? 3 : 2;
        end
      end
    end
  end

  logic [9:0]  log_addr[$];
  logic [15:0] log_data[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("wr_en", 32'(io.wr_en), 32'(exp_we));
      chk("status", status, exp_status);
      if (exp_we) begin
        chk("wr_addr", 32'(io.wr_addr), 32'(exp_addr));
        chk("wr_data", 32'(io.wr_data), 32'(exp_data));
      end
      if (io.wr_en) begin
        log_addr.push_back(io.wr_addr);
        log_data.push_back(io.wr_data);
      end
    end
  end

  function automatic logic [31:0] cw(input bit arm, input bit abort, input logic [1:0] mode,
                                     input logic [7:0] ch, input logic [15:0] lm1);
    return {lm1, ch, 4'b0, mode, abort, arm};
  endfunction

  task automatic drive(input bit v, input logic [7:0] ch, input logic [15:0] d);
    io.in_valid = v;
    io.in_ch    = ch;
    io.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 16'd0);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ctrl = '0; base = '0;
    io.in_valid = 1'b0; io.in_ch = '0; io.in_data = '0;
    #2;
    chk("rst_wr_en", 32'(io.wr_en), 32'd0);
    chk("rst_status", status, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Immediate mode, channel 5, four samples, full round robin
    clear_log();
    ctrl = cw(1, 0, 2'd0, 8'd5, 16'd3);
    idle(2);
    chk("imm_armed_status", status, 32'h0000_0005);
    for (int f = 0; f < 5; f++)
      for (int c = 0; c < 256; c++) drive(1'b1, 8'(c), {8'(f), 8'(c)});
    idle(2);
    chk("imm_status", status, 32'h0004_0002);
    chk("imm_count", 32'(log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk("imm_addr", 32'(log_addr[i]), 32'(i));
      chk("imm_data", 32'(log_data[i]), {16'd0, 8'(i), 8'd5});
    end

    // Threshold mode; software edits after arming must not matter
    ctrl = cw(0, 0, 2'd0, 8'd5, 16'd1);
    idle(1);
    clear_log();
    base = {1'b0, 15'd20, 16'd100};
    ctrl = cw(1, 0, 2'd1, 8'd5, 16'd1);
    idle(2);
    base = {1'b0, 15'd0, 16'd200};
    drive(1'b1, 8'd5, 16'd95);
    drive(1'b1, 8'd4, -16'sd1000);
    drive(1'b1, 8'd5, 16'd81);
    drive(1'b0, 8'd5, -16'sd500);
    drive(1'b1, 8'd5, 16'd80);
    drive(1'b1, 8'd5, 16'd60);
    idle(2);
    chk("thr_count", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() >= 2) begin
      chk("thr_first", 32'(log_data[0]), 32'd80);
      chk("thr_second", 32'(log_data[1]), 32'd60);
    end
    chk("thr_status", status, 32'h0002_0002);

    // Signed extremes
    ctrl = cw(0, 0, 2'd0, 8'd9, 16'd0);
    idle(1);
    clear_log();
    base = {1'b0, 15'h7FFF, 16'h7FFF};
    ctrl = cw(1, 0, 2'd1, 8'd9, 16'd0);
    idle(2);
    drive(1'b1, 8'd9, 16'h0001);
    drive(1'b1, 8'd9, 16'h8000);
    idle(2);
    chk("ext_count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() >= 1) chk("ext_data", 32'(log_data[0]), 32'h0000_8000);
    chk("ext_status", status, 32'h0001_0002);

    // Arm held high after done: no re-arm until it drops and rises again
    idle(5);
    chk("held_status", status, 32'h0001_0002);
    ctrl = cw(0, 0, 2'd0, 8'd2, 16'd7);
    idle(1);
    ctrl = cw(1, 0, 2'd0, 8'd2, 16'd7);
    idle(2);
    chk("rearm_status", status, 32'h0000_0005);

    // Abort on the same cycle as a selected sample
    clear_log();
    drive(1'b1, 8'd2, 16'h0011);
    drive(1'b1, 8'd2, 16'h0022);
    ctrl = cw(1, 1, 2'd0, 8'd2, 16'd7);
    drive(1'b1, 8'd2, 16'h0033);
    ctrl = cw(1, 0, 2'd0, 8'd2, 16'd7);
    idle(3);
    chk("abort_count", 32'(log_addr.size()), 32'd2);
    chk("abort_status", status, 32'h0002_0000);

    // Length clipping
    ctrl = cw(0, 0, 2'd0, 8'd7, 16'hFFFF);
    idle(1);
    clear_log();
    ctrl = cw(1, 0, 2'd0, 8'd7, 16'hFFFF);
    idle(2);
    chk("clip_armed_status", status, 32'h0000_000D);
    for (int i = 0; i < 1030; i++) drive(1'b1, 8'd7, 16'(i));
    idle(2);
    chk("clip_count", 32'(log_addr.size()), 32'd1024);
    if (log_addr.size() > 0) begin
      chk("clip_last_addr", 32'(log_addr[log_addr.size()-1]), 32'd1023);
      chk("clip_last_data", 32'(log_data[log_data.size()-1]), 32'd1023);
    end
    chk("clip_status", status, 32'h0400_000A);
    ctrl = cw(1, 1, 2'd0, 8'd7, 16'hFFFF);
    idle(1);
    ctrl = cw(1, 0, 2'd0, 8'd7, 16'hFFFF);
    idle(2);
    chk("clip_abort_status", status, 32'h0400_0000);

    // Asynchronous reset in the middle of a capture
    ctrl = cw(0, 0, 2'd0, 8'd7, 16'd100);
    idle(1);
    ctrl = cw(1, 0, 2'd0, 8'd7, 16'd100);
    idle(2);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'd7, 16'(16'h100 + i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(io.wr_en), 32'd0);
    chk("arst_wr_addr", 32'(io.wr_addr), 32'd0);
    chk("arst_wr_data", 32'(io.wr_data), 32'd0);
    chk("arst_status", status, 32'd0);
    ctrl = '0;
    io.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_status", status, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
